// File: rtl/logic_block_sequencer.sv
// rtl/logic_block_sequencer.sv - shadow/active config, arming and hit qualification for one logicBlock comparator
module logic_block_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             cfg_commit,
  input  logic             arm,
  input  logic             disarm,
  input  logic             lb_result,
  input  logic             lb_config_invalid,
  output logic [WIDTH-1:0] mask_a,
  output logic [WIDTH-1:0] mask_b,
  output logic [WIDTH-1:0] constant_o,
  output logic             op_b_mux,
  output logic [2:0]       result_mux,
  output logic             prev_config_invalid,
  output logic             trigger,
  output logic             fired,
  output logic             arm_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] hit_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } seqState_t;

  seqState_t curState;

  // Host-visible shadow set; only reaches the comparator on commit.
  logic [WIDTH-1:0] shMaskA;
  logic [WIDTH-1:0] shMaskB;
  logic [WIDTH-1:0] shConst;
  logic             shOpBMux;
  logic [2:0]       shResultMux;
  logic [CNT_W-1:0] shThreshold;
  logic             badWrite;

  logic [CNT_W-1:0] actThreshold;

  logic             cfgAccept;
  logic             commitNow;
  logic             armNow;
  logic             badAddr;
  logic [CNT_W-1:0] effThr;
  logic [CNT_W:0]   hitSum;
  logic             thrReached;

  // cfg_ready is only ever high in IDLE, so an accepted write implies IDLE.
  assign cfgAccept  = cfg_valid && cfg_ready;
  assign commitNow  = cfg_commit && (curState == IDLE);
  // Commit takes priority: the active set is not settled until the edge after commit.
  assign armNow     = arm && !cfg_commit && (curState == IDLE);
  assign badAddr    = (cfg_addr > 3'd4);
  // A zero threshold behaves as a single-hit trigger.
  assign effThr     = (actThreshold == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : actThreshold;
  // One extra bit so the increment can never wrap before the compare.
  assign hitSum     = {1'b0, hit_count} + {{CNT_W{1'b0}}, 1'b1};
  assign thrReached = (hitSum >= {1'b0, effThr});
  assign state      = curState;

  // Shadow writes, atomic shadow->active copy on commit, and the sticky bad-write flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shMaskA             <= '0;
      shMaskB             <= '0;
      shConst             <= '0;
      shOpBMux            <= 1'b0;
      shResultMux         <= 3'd0;
      shThreshold         <= {{(CNT_W-1){1'b0}}, 1'b1};
      badWrite            <= 1'b0;
      mask_a              <= '0;
      mask_b              <= '0;
      constant_o          <= '0;
      op_b_mux            <= 1'b0;
      result_mux          <= 3'd0;
      actThreshold        <= {{(CNT_W-1){1'b0}}, 1'b1};
      prev_config_invalid <= 1'b0;
    end else begin
      if (cfgAccept) begin
        case (cfg_addr)
          3'd0: shMaskA <= cfg_data;
          3'd1: shMaskB <= cfg_data;
          3'd2: shConst <= cfg_data;
          3'd3: begin
            shOpBMux    <= cfg_data[3];
            shResultMux <= cfg_data[2:0];
          end
          3'd4: shThreshold <= cfg_data[CNT_W-1:0];
          default: ;
        endcase
      end
      // Commit copies the pre-edge shadow, so a same-cycle write stays in shadow.
      if (commitNow) begin
        mask_a              <= shMaskA;
        mask_b              <= shMaskB;
        constant_o          <= shConst;
        op_b_mux            <= shOpBMux;
        result_mux          <= shResultMux;
        actThreshold        <= shThreshold;
        prev_config_invalid <= badWrite;
      end
      if (cfgAccept && badAddr) begin
        badWrite <= 1'b1;
      end else if (commitNow) begin
        badWrite <= 1'b0;
      end
    end
  end

  // Sequencer: arm/disarm, consecutive-hit qualification and trigger generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState  <= IDLE;
      hit_count <= '0;
      trigger   <= 1'b0;
      fired     <= 1'b0;
      arm_err   <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      trigger <= 1'b0;
      case (curState)
        IDLE: begin
          cfg_ready <= 1'b1;
          if (armNow) begin
            if (lb_config_invalid) begin
              arm_err <= 1'b1;
            end else begin
              curState  <= ARMED;
              hit_count <= '0;
              arm_err   <= 1'b0;
              cfg_ready <= 1'b0;
            end
          end
        end
        ARMED: begin
          if (disarm) begin
            curState  <= IDLE;
            hit_count <= '0;
            cfg_ready <= 1'b1;
          end else if (lb_result) begin
            if (thrReached) begin
              curState  <= FIRED;
              trigger   <= 1'b1;
              fired     <= 1'b1;
              hit_count <= effThr;
            end else begin
              hit_count <= hitSum[CNT_W-1:0];
            end
          end else begin
            hit_count <= '0;
          end
        end
        FIRED: begin
          if (disarm) begin
            curState  <= IDLE;
            hit_count <= '0;
            fired     <= 1'b0;
            cfg_ready <= 1'b1;
          end
        end
        default: begin
          curState  <= IDLE;
          hit_count <= '0;
          fired     <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_block_sequencer.sv
// tb/tb_logic_block_sequencer.sv - scoreboard bench for logic_block_sequencer against a register-array reference model
module tb_logic_block_sequencer;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [2:0]       cfg_addr = 3'd0;
  logic [WIDTH-1:0] cfg_data = '0;
  logic             cfg_commit = 1'b0;
  logic             arm = 1'b0;
  logic             disarm = 1'b0;
  logic             lb_result = 1'b0;
  logic             lb_config_invalid = 1'b0;
  logic [WIDTH-1:0] mask_a;
  logic [WIDTH-1:0] mask_b;
  logic [WIDTH-1:0] constant_o;
  logic             op_b_mux;
  logic [2:0]       result_mux;
  logic             prev_config_invalid;
  logic             trigger;
  logic             fired;
  logic             arm_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] hit_count;

  always #5 clk = ~clk;

  logic_block_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .arm(arm), .disarm(disarm),
    .lb_result(lb_result), .lb_config_invalid(lb_config_invalid),
    .mask_a(mask_a), .mask_b(mask_b), .constant_o(constant_o),
    .op_b_mux(op_b_mux), .result_mux(result_mux), .prev_config_invalid(prev_config_invalid),
    .trigger(trigger), .fired(fired), .arm_err(arm_err), .state(state), .hit_count(hit_count)
  );

  typedef struct {
    logic [1:0]       st;
    logic [CNT_W-1:0] hc;
    logic             trg;
    logic             fir;
    logic             aerr;
    logic             rdy;
    logic             opb;
    logic [2:0]       rmux;
    logic             pci;
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic [WIDTH-1:0] co;
  } snap_t;

  snap_t expQ[$];
  int compared = 0;
  int mismatched = 0;

  // Reference model: registers as arrays indexed by address, state as an integer.
  logic [WIDTH-1:0] shReg  [5];
  logic [WIDTH-1:0] actReg [5];
  int  mState;
  int  mHits;
  bit  mBad, mPrev, mArmErr, mReady, mTrig;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 5; i++) begin
      shReg[i]  = (i == 4) ? 1 : 0;
      actReg[i] = (i == 4) ? 1 : 0;
    end
    mState = 0; mHits = 0; mBad = 0; mPrev = 0; mArmErr = 0; mReady = 0; mTrig = 0;
  endtask

  task automatic modelStep();
    logic [WIDTH-1:0] old [5];
    bit oldBad;
    bit wrBad;
    int thr;
    if (!rst_n) begin
      modelReset();
      return;
    end
    mTrig = 0;
    if (mState == 0) begin
      old = shReg;
      oldBad = mBad;
      wrBad = 0;
      if (cfg_valid && mReady) begin
        if (cfg_addr == 3) shReg[3] = {28'd0, cfg_data[3:0]};
        else if (cfg_addr == 4) shReg[4] = {16'd0, cfg_data[15:0]};
        else if (cfg_addr < 3) shReg[cfg_addr] = cfg_data;
        else wrBad = 1;
      end
      if (cfg_commit) begin
        actReg = old;
        mPrev  = oldBad;
        mBad   = wrBad;
      end else begin
        mBad = mBad | wrBad;
        if (arm) begin
          if (lb_config_invalid) mArmErr = 1;
          else begin mState = 1; mHits = 0; mArmErr = 0; end
        end
      end
    end else if (disarm) begin
      mState = 0; mHits = 0;
    end else if (mState == 1) begin
      thr = (actReg[4] == 0) ? 1 : int'(actReg[4]);
      if (lb_result) begin
        if (mHits + 1 >= thr) begin mState = 2; mTrig = 1; mHits = thr; end
        else mHits = mHits + 1;
      end else begin
        mHits = 0;
      end
    end
    mReady = (mState == 0);
  endtask

  function automatic snap_t modelSnap();
    snap_t s;
    s.st   = 2'(mState);
    s.hc   = CNT_W'(mHits);
    s.trg  = mTrig;
    s.fir  = (mState == 2);
    s.aerr = mArmErr;
    s.rdy  = mReady;
    s.opb  = actReg[3][3];
    s.rmux = actReg[3][2:0];
    s.pci  = mPrev;
    s.ma   = actReg[0];
    s.mb   = actReg[1];
    s.co   = actReg[2];
    return s;
  endfunction

  // Drive one cycle of inputs, predict the post-edge outputs, hand them to the monitor.
  task automatic step(input bit r, input bit cv, input logic [2:0] ca, input logic [WIDTH-1:0] cd,
                      input bit cm, input bit ar, input bit da, input bit res, input bit inv);
    bit falling;
    falling = rst_n && !r;
    rst_n = r; cfg_valid = cv; cfg_addr = ca; cfg_data = cd;
    cfg_commit = cm; arm = ar; disarm = da; lb_result = res; lb_config_invalid = inv;
    if (falling) begin
      #1;
      check("async_reset_state", 64'(state), 64'd0);
      check("async_reset_hit_count", 64'(hit_count), 64'd0);
      check("async_reset_mask_a", 64'(mask_a), 64'd0);
      check("async_reset_trigger", 64'(trigger), 64'd0);
    end
    modelStep();
    expQ.push_back(modelSnap());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [WIDTH-1:0] d);
    step(1, 1, a, d, 0, 0, 0, 0, 0);
  endtask

  task automatic hit(input bit res);
    step(1, 0, 0, 0, 0, 0, 0, res, 0);
  endtask

  // Monitor: every edge the DUT presents a fresh output set; pop and compare.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("state", 64'(state), 64'(e.st));
        check("hit_count", 64'(hit_count), 64'(e.hc));
        check("trigger", 64'(trigger), 64'(e.trg));
        check("fired", 64'(fired), 64'(e.fir));
        check("arm_err", 64'(arm_err), 64'(e.aerr));
        check("cfg_ready", 64'(cfg_ready), 64'(e.rdy));
        check("op_b_mux", 64'(op_b_mux), 64'(e.opb));
        check("result_mux", 64'(result_mux), 64'(e.rmux));
        check("prev_config_invalid", 64'(prev_config_invalid), 64'(e.pci));
        check("mask_a", 64'(mask_a), 64'(e.ma));
        check("mask_b", 64'(mask_b), 64'(e.mb));
        check("constant_o", 64'(constant_o), 64'(e.co));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    bit cv, cm, ar, da, res, inv, r;
    logic [2:0] ca;
    logic [WIDTH-1:0] cd;
    modelReset();
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h5, 0, 1, 0, 1, 0);
    idle(2);

    // Basic qualification with threshold 3.
    wr(0, 32'hFF); wr(2, 32'h10); wr(3, 32'h2); wr(4, 3);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    hit(1); hit(1); hit(1); hit(1); hit(0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);

    // Reset in the middle of ARMED.
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    hit(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Broken hit run: 1,1,0,1,1,1 then extra hits while FIRED.
    wr(0, 32'hFF); wr(2, 32'h10); wr(3, 32'h2); wr(4, 3);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    hit(1); hit(1); hit(0); hit(1); hit(1); hit(1); hit(1); hit(1);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);

    // Bad address, commit, refused arm, then accepted arm clears arm_err.
    wr(6, 32'h1234);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 1);
    idle(1);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);

    // commit+arm same cycle, then arm, then disarm+arm.
    step(1, 0, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);

    // Threshold 0 behaves as 1; writes while ARMED are refused.
    wr(4, 0); wr(0, 32'hA5A5);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0);
    hit(1); hit(0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) != 0);
      cv  = ($urandom_range(0, 9) < 3);
      ca  = 3'($urandom_range(0, 7));
      cd  = $urandom;
      if (ca == 4) cd = $urandom_range(0, 6);
      cm  = ($urandom_range(0, 99) < 8);
      ar  = ($urandom_range(0, 99) < 15);
      da  = ($urandom_range(0, 99) < 5);
      res = ($urandom_range(0, 9) < 7);
      inv = ($urandom_range(0, 9) < 2);
      step(r, cv, ca, cd, cm, ar, da, res, inv);
    end

    idle(2);
    check("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
